// File: rtl/unary_result_decoder_if.sv
// Handshake bundle between the unary adder result bus and the thermometer decoder.
// The master drives words in and accepts results; the slave is the decoder.
interface unary_result_decoder_if #(
    parameter int NOF_BITS = 8,
    parameter int CW       = $clog2(2 * NOF_BITS + 1)
);
    logic                    in_valid;
    logic [2*NOF_BITS-1:0]   data_in;
    logic                    in_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic [CW-1:0]           count;
    logic                    bubble_err;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, count, bubble_err
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, count, bubble_err
    );
endinterface

// File: rtl/unary_result_decoder.sv
// Serial LSB-first thermometer-code decoder: counts the leading run of 1s and
// flags bubbles (a 1 above the first 0), returning one result per captured word.
module unary_result_decoder #(
    parameter int NOF_BITS = 8,
    parameter int CW       = $clog2(2 * NOF_BITS + 1)
) (
    input logic                    clk,
    input logic                    rst,
    unary_result_decoder_if.slave  bus
);
    localparam int W = 2 * NOF_BITS;

    typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

    state_t          state_q;
    logic [W-1:0]    sreg_q;
    logic [CW-1:0]   acc_q;
    logic [CW-1:0]   count_q;
    logic            zero_seen_q;
    logic            bubble_q;
    logic            bubble_err_q;
    logic            out_valid_q;
    logic            in_ready_q;

    // Scanning stops as soon as the shifted word is empty, so latency tracks
    // the highest set bit rather than the full word width.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            sreg_q       <= '0;
            acc_q        <= '0;
            count_q      <= '0;
            zero_seen_q  <= 1'b0;
            bubble_q     <= 1'b0;
            bubble_err_q <= 1'b0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        sreg_q      <= bus.data_in;
                        acc_q       <= '0;
                        zero_seen_q <= 1'b0;
                        bubble_q    <= 1'b0;
                        in_ready_q  <= 1'b0;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    if (sreg_q == '0) begin
                        count_q      <= acc_q;
                        bubble_err_q <= bubble_q;
                        out_valid_q  <= 1'b1;
                        state_q      <= HOLD;
                    end else begin
                        if (sreg_q[0]) begin
                            if (!zero_seen_q) begin
                                acc_q <= acc_q + CW'(1);
                            end else begin
                                bubble_q <= 1'b1;
                            end
                        end else begin
                            zero_seen_q <= 1'b1;
                        end
                        sreg_q <= sreg_q >> 1;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q  <= 1'b0;
                        count_q      <= '0;
                        bubble_err_q <= 1'b0;
                        in_ready_q   <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.count      = count_q;
    assign bus.bubble_err = bubble_err_q;

endmodule
